// File: rtl/unidade_pc_pkg.sv
// Shared opcodes and FSM state encoding for the program-counter / fetch stage.
package unidade_pc_pkg;

    localparam logic [5:0] OP_IN   = 6'b100000;
    localparam logic [5:0] OP_JUMP = 6'b110000;
    localparam logic [5:0] OP_JAL  = 6'b111000;

    typedef enum logic [1:0] {
        ST_RUN          = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_UNUSED       = 2'd3
    } estado_t;

    function automatic logic is_salto_absoluto(input logic [5:0] opcode);
        return (opcode == OP_JUMP) || (opcode == OP_JAL);
    endfunction

endpackage

// File: rtl/unidade_pc_debounce.sv
// Key synchroniser plus debounce counter: the level flips only after the synced
// key disagrees with it for DEB_CYCLES consecutive cycles.
module debounce_botao #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic nivel
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync0_q, sync1_q;
    logic             nivel_q, nivel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        nivel_d = nivel_q;
        cnt_d   = '0;
        if (sync1_q != nivel_q) begin
            if (cnt_q == CNT_MAX) begin
                nivel_d = ~nivel_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            nivel_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= botao;
            sync1_q <= sync0_q;
            nivel_q <= nivel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign nivel = nivel_q;

endmodule

// File: rtl/unidade_pc.sv
// Program counter, next-PC selection and the key-handshake FSM that lets
// exactly one IN instruction retire per debounced key press.
module unidade_pc
    import unidade_pc_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 10,
    parameter logic [ADDR_W-1:0]    PC_RESET   = '0,
    parameter int unsigned          DEB_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              botao,
    input  logic [5:0]        Modo_Funcao_UC,
    input  logic              halt,
    input  logic              Seletor_Desvio_UC,
    input  logic              flag_desvio,
    input  logic              Seletor_regJr_UC,
    input  logic [ADDR_W-1:0] imediato,
    input  logic [ADDR_W-1:0] reg_jr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_mais_um,
    output logic              clock_botao,
    output logic [1:0]        estado
);

    logic              nivel_botao;
    logic [ADDR_W-1:0] pc_q, pc_d;
    estado_t           estado_q, estado_d;
    logic              op_in;

    debounce_botao #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clock(clock),
        .reset(reset),
        .botao(botao),
        .nivel(nivel_botao)
    );

    assign op_in      = (Modo_Funcao_UC == OP_IN);
    assign pc_mais_um = pc_q + ADDR_W'(1);

    always_comb begin
        pc_d = pc_mais_um;
        if (halt) begin
            pc_d = pc_q;
        end else if (!Seletor_regJr_UC) begin
            pc_d = reg_jr;
        end else if (is_salto_absoluto(Modo_Funcao_UC)) begin
            pc_d = imediato;
        end else if (Seletor_Desvio_UC && flag_desvio) begin
            pc_d = imediato;
        end
    end

    // WAIT_RELEASE masks the key so a held key cannot retire a second IN.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_RUN: begin
                if (op_in) estado_d = halt ? ST_WAIT_PRESS : ST_WAIT_RELEASE;
            end
            ST_WAIT_PRESS: begin
                if (!op_in)     estado_d = ST_RUN;
                else if (!halt) estado_d = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (!nivel_botao) estado_d = ST_RUN;
            end
            default: estado_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q     <= PC_RESET;
            estado_q <= ST_RUN;
        end else begin
            pc_q     <= pc_d;
            estado_q <= estado_d;
        end
    end

    assign pc          = pc_q;
    assign estado      = estado_q;
    assign clock_botao = nivel_botao && (estado_q != ST_WAIT_RELEASE);

endmodule

// File: tb/tb_unidade_pc.sv
// Bench for unidade_pc: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the fetch stage.
module tb_unidade_pc;

    localparam int AW  = 4;
    localparam int DEB = 4;
    localparam int PCM = 1 << AW;

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_ADD   = 6'b000001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_UNDEF = 6'b010111;
    localparam logic [5:0] OP_IN    = 6'b100000;
    localparam logic [5:0] OP_JUMP  = 6'b110000;
    localparam logic [5:0] OP_JAL   = 6'b111000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          botao = 1'b0;
    logic [5:0]    op = OP_ADD;
    logic          halt = 1'b0;
    logic          sel_desvio = 1'b0;
    logic          flag = 1'b0;
    logic          sel_jr = 1'b1;
    logic [AW-1:0] imm = '0;
    logic [AW-1:0] rjr = '0;
    logic [AW-1:0] pc, pc_mais_um;
    logic          clock_botao;
    logic [1:0]    estado;

    unidade_pc #(
        .ADDR_W(AW),
        .PC_RESET(4'd0),
        .DEB_CYCLES(DEB)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .botao(botao),
        .Modo_Funcao_UC(op),
        .halt(halt),
        .Seletor_Desvio_UC(sel_desvio),
        .flag_desvio(flag),
        .Seletor_regJr_UC(sel_jr),
        .imediato(imm),
        .reg_jr(rjr),
        .pc(pc),
        .pc_mais_um(pc_mais_um),
        .clock_botao(clock_botao),
        .estado(estado)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: key seen two edges late; the debounced level flips once
    // the last DEB delayed samples all disagree with it.
    int m_pc, m_st;
    bit m_lvl, m_d1, m_d2;
    bit win[$];

    function automatic bit m_cb();
        return m_lvl && (m_st != 2);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_st = 0; m_lvl = 0; m_d1 = 0; m_d2 = 0;
        win.delete();
    endtask

    task automatic model_edge();
        int npc, nst;
        bit all_diff;
        if (halt)                             npc = m_pc;
        else if (!sel_jr)                     npc = int'(rjr);
        else if (op == OP_JUMP || op == OP_JAL) npc = int'(imm);
        else if (sel_desvio && flag)          npc = int'(imm);
        else                                  npc = (m_pc + 1) % PCM;
        nst = m_st;
        if (m_st == 0 && op == OP_IN)      nst = halt ? 1 : 2;
        else if (m_st == 1 && op != OP_IN) nst = 0;
        else if (m_st == 1 && !halt)       nst = 2;
        else if (m_st == 2 && !m_lvl)      nst = 0;
        win.push_back(m_d2);
        if (win.size() > DEB) void'(win.pop_front());
        all_diff = (win.size() == DEB);
        foreach (win[i]) if (win[i] == m_lvl) all_diff = 0;
        if (all_diff) m_lvl = !m_lvl;
        m_d2 = m_d1; m_d1 = botao;
        m_pc = npc; m_st = nst;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
        chk({tag, ".estado"}, 32'(estado), 32'(m_st));
        chk({tag, ".clock_botao"}, 32'(clock_botao), 32'(m_cb()));
        chk({tag, ".pc_mais_um"}, 32'(pc_mais_um), 32'((m_pc + 1) % PCM));
    endtask

    // auto_halt mimics the control unit: IN stalls until the key is offered.
    task automatic step(input string tag, input bit auto_halt);
        if (auto_halt && op == OP_IN) halt = !m_cb();
        model_edge();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        int first, max_cb, hold;
        model_reset();
        #12;
        chk_all("reset0");
        rst_n = 1'b1;

        // 1: sequential advance, then async reset in the middle of a cycle
        for (int i = 1; i <= 4; i++) step("t1.add", 0);
        chk("t1.pc4", 32'(pc), 32'd4);
        do_reset();
        for (int i = 1; i <= 3; i++) step("t1b.add", 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1.midreset_pc", 32'(pc), 32'd0);
        chk_all("t1.midreset");
        rst_n = 1'b1;

        // 2: wrap and conditional branch
        op = OP_JUMP; imm = 4'd15; step("t2.jump15", 0);
        op = OP_NOP;               step("t2.wrap", 0);
        chk("t2.wrap_pc", 32'(pc), 32'd0);
        op = OP_BEQ; sel_desvio = 1; flag = 1; imm = 4'd9; step("t2.beq_t", 0);
        flag = 0;                                          step("t2.beq_nt", 0);
        chk("t2.beq_nt_pc", 32'(pc), 32'd10);
        sel_desvio = 0;

        // 3: JR beats JUMP; halt beats JR
        op = OP_JUMP; imm = 4'd2; sel_jr = 0; rjr = 4'd5; step("t3.jr", 0);
        rjr = 4'd12; halt = 1;                            step("t3.halt", 0);
        chk("t3.halt_pc", 32'(pc), 32'd5);
        halt = 0; sel_jr = 1;

        // 4: IN waits for a bouncing key
        op = OP_IN; botao = 0;
        step("t4.in", 1);
        chk("t4.estado_wp", 32'(estado), 32'd1);
        botao = 1; step("t4.b1", 1);
        botao = 0; step("t4.b0", 1);
        botao = 1;
        first = 0;
        for (int i = 1; i <= 10 && first == 0; i++) begin
            step("t4.stable", 1);
            if (clock_botao === 1'b1) first = i;
        end
        chk("t4.latency", 32'(first), 32'd6);
        step("t4.advance", 1);
        chk("t4.adv_pc", 32'(pc), 32'd6);
        chk("t4.adv_estado", 32'(estado), 32'd2);

        // 5: second IN with key held stalls until release and new press
        for (int i = 0; i < 4; i++) step("t5.held", 1);
        botao = 0;
        for (int i = 0; i < 10; i++) step("t5.release", 1);
        botao = 1;
        for (int i = 0; i < 12; i++) step("t5.press", 1);
        chk("t5.one_advance", 32'(pc), 32'd7);

        // 6: 3-cycle glitch must not reach the debounced level
        op = OP_NOP; halt = 0; botao = 0;
        for (int i = 0; i < 10; i++) step("t6.settle", 0);
        botao = 1;
        max_cb = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) botao = 0;
            step("t6.glitch", 0);
            if (clock_botao !== 1'b0) max_cb = 1;
        end
        chk("t6.glitch_cb", 32'(max_cb), 32'd0);

        // randomized traffic
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = OP_ADD;
                2:       op = OP_NOP;
                3:       op = OP_JUMP;
                4:       op = OP_JAL;
                5:       op = OP_BEQ;
                6:       op = OP_UNDEF;
                default: op = OP_IN;
            endcase
            imm        = AW'($urandom);
            rjr        = AW'($urandom);
            sel_jr     = ($urandom_range(0, 7) != 0);
            sel_desvio = (op == OP_BEQ) ? 1'b1 : ($urandom_range(0, 9) == 0);
            flag       = 1'($urandom);
            halt       = ($urandom_range(0, 5) == 0);
            if (hold == 0) begin
                botao = 1'($urandom);
                hold  = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            if (i == 300) begin
                #2;
                do_reset();
            end
            step("rand", 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
